// File: rtl/uart_rx_framed_if.sv
// Output stream of the framed UART receiver: the received payload plus its
// per-frame error flags, and the sticky overrun flag. The handshake is valid/ready.
//   master : receiver side (drives data, valid and flags; samples in_ready)
//   slave  : consumer side (samples data, valid and flags; drives in_ready)
interface uart_rx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 in_ready;
  logic                 out_parity_err;
  logic                 out_frame_err;
  logic                 out_overrun;

  modport master (
    output out_data, out_valid, out_parity_err, out_frame_err, out_overrun,
    input  in_ready
  );

  modport slave (
    input  out_data, out_valid, out_parity_err, out_frame_err, out_overrun,
    output in_ready
  );
endinterface

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver. It samples each bit at mid-bit, rejects false
// starts, and synchronises the raw line. Each frame goes into a valid/ready
// output register together with its parity-error and frame-error flags.
// When that register is still full, a new frame is dropped and the sticky
// overrun flag is set.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_serial  raw serial line, idle high, asynchronous to clk
//   out_busy   high while a frame is being received (not IDLE / WAIT_HIGH)
//   rx         output stream (data, valid, ready, parity/frame/overrun flags)
module uart_rx_framed #(
  parameter int CLOCKS_PER_BIT = 4,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_serial,
  output logic             out_busy,
  uart_rx_framed_if.master rx
);

  localparam int HALF = CLOCKS_PER_BIT / 2;
  localparam int PB   = (PARITY != 0) ? 1 : 0;
  localparam int N    = DATA_BITS + PB + STOP_BITS;
  localparam int CW   = $clog2(CLOCKS_PER_BIT);
  localparam int BW   = $clog2(N + 1);

  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT   = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   perr, perr_n;
  logic                   ferr, ferr_n;
  logic                   done;
  logic                   tick;

  // Synchronizer: resets to idle-high so that releasing reset cannot look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], in_serial};
  end

  assign s        = sync[SYNC_STAGES-1];
  assign tick     = (cnt == '0);
  assign out_busy = (state != S_IDLE) && (state != S_WAIT_HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
    end
  end

  // Each bit is sampled once, when the cycle counter reaches 0, and the counter then reloads.
  // bit_cnt counts the samples taken within the current state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    perr_n  = perr;
    ferr_n  = ferr;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!s) begin
          cnt_n   = CNT_HALF;
          bit_n   = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else if (s) begin
          state_n = S_IDLE;
        end else begin
          cnt_n   = CNT_BIT;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else begin
          cnt_n   = CNT_BIT;
          shreg_n = {s, shreg[DATA_BITS-1:1]};
          if (bit_cnt == LAST_DATA) begin
            bit_n   = '0;
            state_n = (PB != 0) ? S_PAR : S_STOP;
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
      end
      S_PAR: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else begin
          cnt_n   = CNT_BIT;
          perr_n  = (^shreg) ^ s ^ ODD;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else begin
          ferr_n = ferr | ~s;
          if (bit_cnt == LAST_STOP) begin
            // No wait for the end of the stop bit. This lets back-to-back frames be caught.
            done    = 1'b1;
            cnt_n   = '0;
            bit_n   = '0;
            state_n = ferr_n ? S_WAIT_HIGH : S_IDLE;
          end else begin
            cnt_n = CNT_BIT;
            bit_n = bit_cnt + BW'(1);
          end
        end
      end
      S_WAIT_HIGH: begin
        if (s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output register: the frame is loaded at the edge that ends the last stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.out_data       <= '0;
      rx.out_valid      <= 1'b0;
      rx.out_parity_err <= 1'b0;
      rx.out_frame_err  <= 1'b0;
      rx.out_overrun    <= 1'b0;
    end else if (done) begin
      if (rx.out_valid && !rx.in_ready) begin
        rx.out_overrun <= 1'b1;
      end else begin
        rx.out_data       <= shreg_n;
        rx.out_parity_err <= perr_n;
        rx.out_frame_err  <= ferr_n;
        rx.out_valid      <= 1'b1;
        if (rx.out_valid) rx.out_overrun <= 1'b0;
      end
    end else if (rx.out_valid && rx.in_ready) begin
      rx.out_valid   <= 1'b0;
      rx.out_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed. dut0 is 8N1 and dut1 is 8E1, both with CLOCKS_PER_BIT = 4.
module tb_uart_rx_framed;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser0 = 1'b1;
  logic ser1 = 1'b1;
  logic busy0, busy1;

  uart_rx_framed_if #(.DATA_BITS(8)) if0 ();
  uart_rx_framed_if #(.DATA_BITS(8)) if1 ();

  uart_rx_framed #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2))
    dut0 (.clk(clk), .rst_n(rst_n), .in_serial(ser0), .out_busy(busy0), .rx(if0));
  uart_rx_framed #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2))
    dut1 (.clk(clk), .rst_n(rst_n), .in_serial(ser1), .out_busy(busy1), .rx(if1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Count the cycles in which out_valid is high, and capture what was presented.
  int       vld0 = 0, vld1 = 0, vcyc0 = 0;
  logic [7:0] cap0 = '0, cap1 = '0;
  logic     cpe0 = 1'b0, cfe0 = 1'b0, cpe1 = 1'b0, cfe1 = 1'b0;
  always @(negedge clk) begin
    if (if0.out_valid) begin
      vld0  <= vld0 + 1;
      vcyc0 <= cyc;
      cap0  <= if0.out_data;
      cpe0  <= if0.out_parity_err;
      cfe0  <= if0.out_frame_err;
    end
    if (if1.out_valid) begin
      vld1 <= vld1 + 1;
      cap1 <= if1.out_data;
      cpe1 <= if1.out_parity_err;
      cfe1 <= if1.out_frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive n line bits LSB first, 4 clocks each. Called and returns at posedge+1.
  task automatic send(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) ser0 = bits[i];
      else          ser1 = bits[i];
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] frame8(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] framep(input logic [7:0] d, input logic p);
    return {5'b0, 1'b1, p, d, 1'b0};
  endfunction

  int base, base1, start;

  initial begin
    if0.in_ready = 1'b1;
    if1.in_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", if0.out_valid, 0);
    check("rst_data", if0.out_data, 0);
    check("rst_flags", {if0.out_parity_err, if0.out_frame_err, if0.out_overrun}, 0);
    check("rst_busy", busy0, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 1: 0xA5, 8N1, latency t0+39 = c0+41 (two synchronizer cycles)
    base = vld0; start = cyc;
    send(0, frame8(8'hA5), 10);
    repeat (10) @(posedge clk);
    #1;
    check("a5_count", vld0 - base, 1);
    check("a5_latency", vcyc0 - start, 41);
    check("a5_data", cap0, 8'hA5);
    check("a5_flags", {cpe0, cfe0, if0.out_overrun}, 0);

    // 2: one-cycle low glitch -> false start
    base = vld0;
    ser0 = 1'b0;
    @(posedge clk); #1;
    ser0 = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("glitch_busy_hi", busy0, 1);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("glitch_busy_lo", busy0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("glitch_novalid", vld0 - base, 0);

    // 3: even parity, 0x03 with wrong then correct parity bit
    base1 = vld1;
    send(1, framep(8'h03, 1'b1), 11);
    repeat (10) @(posedge clk);
    #1;
    check("par_bad_count", vld1 - base1, 1);
    check("par_bad_data", cap1, 8'h03);
    check("par_bad_perr", cpe1, 1);
    check("par_bad_ferr", cfe1, 0);
    send(1, framep(8'h03, 1'b0), 11);
    repeat (10) @(posedge clk);
    #1;
    check("par_ok_data", cap1, 8'h03);
    check("par_ok_perr", cpe1, 0);

    // 4: overrun with the register full
    if0.in_ready = 1'b0;
    send(0, frame8(8'h11), 10);
    send(0, frame8(8'h22), 10);
    repeat (10) @(posedge clk);
    #1;
    check("ovr_valid", if0.out_valid, 1);
    check("ovr_data", if0.out_data, 8'h11);
    check("ovr_flag", if0.out_overrun, 1);
    @(posedge clk); #1;
    if0.in_ready = 1'b1;
    @(negedge clk);
    check("ovr_hs_valid", if0.out_valid, 1);
    @(posedge clk); #1;
    check("ovr_after_valid", if0.out_valid, 0);
    check("ovr_after_flag", if0.out_overrun, 0);

    // 5: break, then a clean frame
    base = vld0;
    ser0 = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    check("brk_count", vld0 - base, 1);
    check("brk_data", cap0, 8'h00);
    check("brk_ferr", cfe0, 1);
    check("brk_wait_busy", busy0, 0);
    ser0 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    base = vld0;
    send(0, frame8(8'h5A), 10);
    repeat (10) @(posedge clk);
    #1;
    check("post_brk_count", vld0 - base, 1);
    check("post_brk_data", cap0, 8'h5A);
    check("post_brk_ferr", cfe0, 0);

    // 6: asynchronous reset in the middle of DATA
    if0.in_ready = 1'b0;
    send(0, frame8(8'h3C), 10);
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_data", if0.out_data, 8'h3C);
    send(0, 16'h000A, 4);
    check("mid_busy", busy0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", if0.out_valid, 0);
    check("arst_data", if0.out_data, 0);
    check("arst_busy", busy0, 0);
    ser0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("post_rst_valid", if0.out_valid, 0);
    check("post_rst_busy", busy0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
